aes_resp_framer: RTL and testbench



---
 rtl/aes_resp_framer_pkg.sv | 28 ++
 rtl/aes_resp_framer_if.sv | 29 ++
 rtl/aes_resp_framer_gap_timer.sv | 36 +++
 rtl/aes_resp_framer.sv | 162 ++++++++++++++++
 tb/tb_aes_resp_framer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_resp_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : framer_pkg
//  Description : Shared types and constants for the AES response framer:
//                state encoding, base frame length, default header byte and
//                the byte-index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_HOLD  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } framer_state_e;

   // Header + status + 16 ciphertext bytes; checksum (if enabled) is extra.
   localparam int         FRAME_LEN_BASE   = 18;
   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
   localparam int         IDX_W            = 5;

   typedef logic [IDX_W-1:0] idx_t;

endpackage : framer_pkg
`default_nettype wire

// File: rtl/aes_resp_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_resp_framer_if
//  Description : Bundles the result handshake (AES/glitch capture side) and
//                the byte interface toward the UART transmitter.
//                master = framer side, slave = surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_resp_framer_if;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   logic         glitch_flag;
   logic [6:0]   sensor_word;
   logic         tx_start;
   logic [7:0]   tx_data;
   logic         tx_busy;

   modport master (
      input  res_valid, res_data, glitch_flag, sensor_word, tx_busy,
      output res_ready, tx_start, tx_data
   );

   modport slave (
      output res_valid, res_data, glitch_flag, sensor_word, tx_busy,
      input  res_ready, tx_start, tx_data
   );
endinterface : aes_resp_framer_if
`default_nettype wire

// File: rtl/aes_resp_framer_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : framer_gap_timer
//  Description : Loadable down-counter that times the idle gap between bytes.
//                A load starts a run of CYCLES clocks; o_done is high in the
//                last of them (and whenever the counter is idle at zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module framer_gap_timer #(
   parameter int CYCLES = 1
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic i_load,
   output logic      o_done
);
   localparam int                CNT_W      = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0]  c_load_val = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // Load the remaining-cycle count, then count down to zero and hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= c_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule : framer_gap_timer
`default_nettype wire

// File: rtl/aes_resp_framer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_resp_framer
//  Description : Captures one AES result + glitch flag + sensor word and sends
//                it to the UART transmitter as a byte frame:
//                HDR, {glitch, sensor}, 16 ciphertext bytes (MSB first) and,
//                when FRAMER_CHECKSUM_EN is defined, an XOR checksum byte.
//                Bytes are paced by tx_busy plus GAP_CYCLES idle clocks.
//  Config      : `define FRAMER_CHECKSUM_EN -> 19-byte frame with checksum
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_resp_framer
   import framer_pkg::*;
#(
   parameter int         GAP_CYCLES = 20000,
   parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEFAULT
) (
   input  wire logic          clk,
   input  wire logic          reset,
   aes_resp_framer_if.master  bus,
   output logic               busy,
   output logic               frame_done
);
`ifdef FRAMER_CHECKSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
   localparam idx_t c_last_idx = idx_t'(FRAME_LEN - 1);
   localparam idx_t c_buf_end  = idx_t'(FRAME_LEN_BASE);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_START = ST_START;
   localparam logic [2:0] S_HOLD  = ST_HOLD;
   localparam logic [2:0] S_WAIT  = ST_WAIT;
   localparam logic [2:0] S_GAP   = ST_GAP;
   localparam logic [2:0] S_DONE  = ST_DONE;

   logic [2:0]   r_state;
   idx_t         r_idx;
   logic [143:0] r_buf;
   logic [7:0]   r_tx_data;

   logic [7:0]   w_buf_bytes [0:FRAME_LEN_BASE-1];
   logic [7:0]   w_byte;
   logic         w_last;
   logic         w_wait_exit;
   logic         w_gap_load;
   logic         w_gap_done;

   // Byte view of the frame buffer: entry 0 is the header (top bits).
   for (genvar gi = 0; gi < FRAME_LEN_BASE; gi++) begin : g_bytes
      assign w_buf_bytes[gi] = r_buf[8*(FRAME_LEN_BASE-1-gi) +: 8];
   end

`ifdef FRAMER_CHECKSUM_EN
   logic [7:0] r_csum;

   // Running XOR over the bytes already started; cleared on each capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_csum <= '0;
      end else if (r_state == S_IDLE && bus.res_valid) begin
         r_csum <= '0;
      end else if (r_state == S_START && r_idx < c_buf_end) begin
         r_csum <= r_csum ^ w_byte;
      end
   end
`endif

   // Current byte: buffer entry by index, or the checksum past the buffer.
   always_comb begin
      w_byte = 8'h00;
      if (r_idx < c_buf_end) begin
         w_byte = w_buf_bytes[r_idx];
      end
`ifdef FRAMER_CHECKSUM_EN
      else begin
         w_byte = r_csum;
      end
`endif
   end

   assign w_last      = (r_idx == c_last_idx);
   assign w_wait_exit = (r_state == S_WAIT) && !bus.tx_busy;
   assign w_gap_load  = w_wait_exit && !w_last;

   if (GAP_CYCLES > 0) begin : g_gap_timer
      framer_gap_timer #(
         .CYCLES (GAP_CYCLES)
      ) u_gap_timer (
         .clk    (clk),
         .reset  (reset),
         .i_load (w_gap_load),
         .o_done (w_gap_done)
      );
   end else begin : g_no_gap_timer
      logic w_unused_gap_load;
      assign w_unused_gap_load = w_gap_load;
      assign w_gap_done        = 1'b1;
   end

   // Frame sequencer: capture, then START/HOLD/WAIT[/GAP] per byte, then DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_buf     <= '0;
         r_tx_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.res_valid) begin
                  r_buf   <= {HDR_BYTE, bus.glitch_flag, bus.sensor_word, bus.res_data};
                  r_idx   <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               // Hold the launched byte so tx_data stays put until the next start.
               r_tx_data <= w_byte;
               r_state   <= S_HOLD;
            end
            S_HOLD: begin
               // Transmitter needs a cycle to raise busy; ignore it here.
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (!bus.tx_busy) begin
                  r_idx <= r_idx + 1'b1;
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else if (GAP_CYCLES == 0) begin
                     r_state <= S_START;
                  end else begin
                     r_state <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (w_gap_done) begin
                  r_state <= S_START;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.res_ready = (r_state == S_IDLE) && !reset;
   assign bus.tx_start  = (r_state == S_START);
   assign bus.tx_data   = (r_state == S_START) ? w_byte : r_tx_data;
   assign busy          = (r_state != S_IDLE);
   assign frame_done    = (r_state == S_DONE);

endmodule : aes_resp_framer
`default_nettype wire

// File: tb/tb_aes_resp_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_resp_framer
//  Description : Self-checking bench for aes_resp_framer. Instance A uses a
//                4-cycle gap and a transmitter model busy for 10 cycles after
//                each start; instance B uses no gap and a never-busy
//                transmitter. Frames are checked against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_resp_framer;

   localparam int GAP_A    = 4;
   localparam int BUSY_LEN = 10;
`ifdef FRAMER_CHECKSUM_EN
   localparam int EXP_LEN = 19;
`else
   localparam int EXP_LEN = 18;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic busy_a, done_a, busy_b, done_b;

   aes_resp_framer_if bus_a ();
   aes_resp_framer_if bus_b ();

   aes_resp_framer #(.GAP_CYCLES(GAP_A), .HDR_BYTE(8'hA5)) dut_a (
      .clk(clk), .reset(rst_a), .bus(bus_a), .busy(busy_a), .frame_done(done_a));

   aes_resp_framer #(.GAP_CYCLES(0), .HDR_BYTE(8'hA5)) dut_b (
      .clk(clk), .reset(rst_b), .bus(bus_b), .busy(busy_b), .frame_done(done_b));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model for A: busy through the 10 cycles following a start.
   int xmit_cnt = 0;
   always @(negedge clk) begin
      if (bus_a.tx_start) xmit_cnt <= BUSY_LEN + 1;
      else if (xmit_cnt != 0) xmit_cnt <= xmit_cnt - 1;
   end
   assign bus_a.tx_busy = (xmit_cnt != 0);
   assign bus_b.tx_busy = 1'b0;

   // Output monitors.
   logic [7:0] q_bytes_a [$];
   int         q_cyc_a   [$];
   logic [7:0] q_bytes_b [$];
   int         q_cyc_b   [$];
   int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
   int ready_viol_a = 0, stab_viol_a = 0;
   logic [7:0] last_data_a = 8'h00;

   always @(negedge clk) begin
      if (bus_a.tx_start) begin
         q_bytes_a.push_back(bus_a.tx_data);
         q_cyc_a.push_back(cyc);
         last_data_a <= bus_a.tx_data;
      end else if (busy_a && bus_a.tx_data !== last_data_a) begin
         stab_viol_a++;
      end
      if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
      if (busy_a && bus_a.res_ready) ready_viol_a++;
      if (bus_b.tx_start) begin
         q_bytes_b.push_back(bus_b.tx_data);
         q_cyc_b.push_back(cyc);
      end
      if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
   end

   // Reference frame built straight from the frame definition.
   logic [7:0] exp_f [0:18];
   task automatic model_frame(input logic [127:0] d, input logic g, input logic [6:0] s);
      logic [7:0] x;
      exp_f[0] = 8'hA5;
      exp_f[1] = {g, s};
      for (int k = 0; k < 16; k++) exp_f[2+k] = d[127-8*k -: 8];
      x = 8'h00;
      for (int k = 0; k < 18; k++) x ^= exp_f[k];
      exp_f[18] = x;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Present a result on A and hold it until accepted; cap_cyc = capture cycle.
   task automatic send_a(input logic [127:0] d, input logic g, input logic [6:0] s,
                         output int cap_cyc, output bit ok);
      bus_a.res_valid   = 1'b1;
      bus_a.res_data    = d;
      bus_a.glitch_flag = g;
      bus_a.sensor_word = s;
      ok = 1'b0;
      cap_cyc = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (bus_a.res_ready) begin ok = 1'b1; cap_cyc = cyc; end
         step();
      end
      bus_a.res_valid   = 1'b0;
      bus_a.res_data    = {$urandom, $urandom, $urandom, $urandom};
      bus_a.glitch_flag = 1'($urandom);
      bus_a.sensor_word = 7'($urandom);
   endtask

   task automatic wait_done_a(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (done_cnt_a >= target) ok = 1'b1;
         else step();
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.res_valid = 1'b1; bus_b.res_valid = 1'b1;
      repeat (3) step();
      n_checks++;
      if (bus_a.res_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_reset: got %b want 0", bus_a.res_ready); end
      bus_a.res_valid = 1'b0; bus_b.res_valid = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      step();
      n_checks++;
      if (bus_a.res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus_a.res_ready); end
      n_checks++;
      if (bus_a.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", bus_a.tx_start); end
      n_checks++;
      if (bus_a.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus_a.tx_data); end
      n_checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy_a, done_a); end
      n_checks++;
      if (bus_b.res_ready !== 1'b1 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got ready=%b busy=%b want 1/0", bus_b.res_ready, busy_b); end
      repeat (3) step();
      n_checks++;
      if (q_bytes_a.size() !== 0) begin n_fail++; $display("FAIL reset_wins_capture: got %0d bytes want 0", q_bytes_a.size()); end
   endtask

   task automatic test_zero_frame();
      int cap; bit ok;
      q_bytes_a.delete(); q_cyc_a.delete();
      model_frame(128'h0, 1'b1, 7'h00);
      send_a(128'h0, 1'b1, 7'h00, cap, ok);
      wait_done_a(1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL zero_done_timeout: got %0d dones want 1", done_cnt_a); return; end
      n_checks++;
      if (q_bytes_a.size() != EXP_LEN) begin n_fail++; $display("FAIL zero_len: got %0d want %0d", q_bytes_a.size(), EXP_LEN); return; end
      n_checks++;
      if (q_cyc_a[0] != cap + 1) begin n_fail++; $display("FAIL first_latency: got %0d want %0d", q_cyc_a[0] - cap, 1); end
      for (int i = 0; i < EXP_LEN; i++) begin
         n_checks++;
         if (q_bytes_a[i] !== exp_f[i]) begin n_fail++; $display("FAIL zero_byte%0d: got %h want %h", i, q_bytes_a[i], exp_f[i]); end
      end
      for (int i = 1; i < EXP_LEN; i++) begin
         n_checks++;
         if (q_cyc_a[i] - q_cyc_a[i-1] != BUSY_LEN + GAP_A + 2) begin
            n_fail++; $display("FAIL byte_spacing%0d: got %0d want %0d", i, q_cyc_a[i] - q_cyc_a[i-1], BUSY_LEN + GAP_A + 2);
         end
      end
      n_checks++;
      if (done_cyc_a != q_cyc_a[EXP_LEN-1] + BUSY_LEN + 2) begin
         n_fail++; $display("FAIL done_timing: got %0d want %0d", done_cyc_a - q_cyc_a[EXP_LEN-1], BUSY_LEN + 2);
      end
      step();
      n_checks++;
      if (done_cnt_a != 1) begin n_fail++; $display("FAIL done_once: got %0d want 1", done_cnt_a); end
   endtask

   task automatic test_known_vector();
      int cap; bit ok; int base;
      logic [127:0] d;
      d = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      q_bytes_a.delete(); q_cyc_a.delete();
      base = done_cnt_a;
      model_frame(d, 1'b0, 7'h15);
      send_a(d, 1'b0, 7'h15, cap, ok);
      wait_done_a(base + 1, ok);
      n_checks++;
      if (!ok || q_bytes_a.size() != EXP_LEN) begin n_fail++; $display("FAIL kv_len: got %0d want %0d", q_bytes_a.size(), EXP_LEN); return; end
      n_checks++;
      if (q_bytes_a[1] !== 8'h15) begin n_fail++; $display("FAIL kv_status: got %h want 15", q_bytes_a[1]); end
      for (int i = 0; i < EXP_LEN; i++) begin
         n_checks++;
         if (q_bytes_a[i] !== exp_f[i]) begin n_fail++; $display("FAIL kv_byte%0d: got %h want %h", i, q_bytes_a[i], exp_f[i]); end
      end
   endtask

   task automatic test_random();
      int cap; bit ok; int base;
      logic [127:0] d; logic g; logic [6:0] s;
      for (int f = 0; f < 3; f++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         g = 1'($urandom); s = 7'($urandom);
         q_bytes_a.delete(); q_cyc_a.delete();
         base = done_cnt_a;
         model_frame(d, g, s);
         send_a(d, g, s, cap, ok);
         wait_done_a(base + 1, ok);
         n_checks++;
         if (!ok || q_bytes_a.size() != EXP_LEN) begin n_fail++; $display("FAIL rnd_len%0d: got %0d want %0d", f, q_bytes_a.size(), EXP_LEN); continue; end
         for (int i = 0; i < EXP_LEN; i++) begin
            n_checks++;
            if (q_bytes_a[i] !== exp_f[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h want %h", f, i, q_bytes_a[i], exp_f[i]); end
         end
         repeat ($urandom_range(0, 5)) step();
      end
   endtask

   task automatic test_back_to_back();
      int cap1, cap2; bit ok; int base;
      logic [127:0] d1, d2;
      logic [7:0] exp1 [0:18];
      d1 = {$urandom, $urandom, $urandom, $urandom};
      d2 = ~d1;
      q_bytes_a.delete(); q_cyc_a.delete();
      base = done_cnt_a;
      model_frame(d1, 1'b1, 7'h2a);
      exp1 = exp_f;
      send_a(d1, 1'b1, 7'h2a, cap1, ok);
      send_a(d2, 1'b0, 7'h55, cap2, ok);   // held high for the whole first frame
      n_checks++;
      if (!ok || done_cnt_a != base + 1 || cap2 != done_cyc_a + 1) begin
         n_fail++; $display("FAIL b2b_second_capture: got cycle %0d want %0d", cap2, done_cyc_a + 1);
      end
      n_checks++;
      if (q_bytes_a.size() != EXP_LEN + 1) begin n_fail++; $display("FAIL b2b_first_len: got %0d want %0d", q_bytes_a.size() - 1, EXP_LEN); end
      wait_done_a(base + 2, ok);
      model_frame(d2, 1'b0, 7'h55);
      n_checks++;
      if (!ok || q_bytes_a.size() != 2 * EXP_LEN) begin n_fail++; $display("FAIL b2b_total_len: got %0d want %0d", q_bytes_a.size(), 2 * EXP_LEN); return; end
      for (int i = 0; i < EXP_LEN; i++) begin
         n_checks++;
         if (q_bytes_a[i] !== exp1[i] || q_bytes_a[EXP_LEN+i] !== exp_f[i]) begin
            n_fail++; $display("FAIL b2b_byte%0d: got %h/%h want %h/%h", i, q_bytes_a[i], q_bytes_a[EXP_LEN+i], exp1[i], exp_f[i]);
         end
      end
      n_checks++;
      if (ready_viol_a != 0) begin n_fail++; $display("FAIL ready_while_busy: got %0d cycles want 0", ready_viol_a); end
      n_checks++;
      if (stab_viol_a != 0) begin n_fail++; $display("FAIL tx_data_stable: got %0d changes want 0", stab_viol_a); end
   endtask

   task automatic test_reset_mid_frame();
      int cap; bit ok; int base;
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      q_bytes_a.delete(); q_cyc_a.delete();
      base = done_cnt_a;
      send_a(d, 1'b0, 7'h01, cap, ok);
      for (int i = 0; i < 500 && q_bytes_a.size() < 8; i++) step();
      n_checks++;
      if (q_bytes_a.size() != 8) begin n_fail++; $display("FAIL mid_reach_byte7: got %0d bytes want 8", q_bytes_a.size()); end
      step(); step();               // now in WAIT for byte 7
      rst_a = 1'b1;
      step();
      n_checks++;
      if (busy_a !== 1'b0 || bus_a.tx_start !== 1'b0 || done_a !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got busy=%b start=%b done=%b want 0/0/0", busy_a, bus_a.tx_start, done_a);
      end
      rst_a = 1'b0;
      repeat (30) step();
      n_checks++;
      if (done_cnt_a != base || q_bytes_a.size() != 8) begin
         n_fail++; $display("FAIL mid_no_done: got dones=%0d bytes=%0d want %0d/8", done_cnt_a - base, q_bytes_a.size(), 0);
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      model_frame(d, 1'b1, 7'h7f);
      send_a(d, 1'b1, 7'h7f, cap, ok);
      wait_done_a(base + 1, ok);
      n_checks++;
      if (!ok || q_bytes_a.size() != 8 + EXP_LEN) begin n_fail++; $display("FAIL mid_new_len: got %0d want %0d", q_bytes_a.size() - 8, EXP_LEN); return; end
      for (int i = 0; i < EXP_LEN; i++) begin
         n_checks++;
         if (q_bytes_a[8+i] !== exp_f[i]) begin n_fail++; $display("FAIL mid_new_byte%0d: got %h want %h", i, q_bytes_a[8+i], exp_f[i]); end
      end
   endtask

   task automatic test_zero_gap();
      bit ok; int t0;
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      model_frame(d, 1'b0, 7'h33);
      bus_b.res_valid = 1'b1; bus_b.res_data = d;
      bus_b.glitch_flag = 1'b0; bus_b.sensor_word = 7'h33;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (bus_b.res_ready) ok = 1'b1;
         step();
      end
      bus_b.res_valid = 1'b0;
      for (int i = 0; i < 500 && done_cnt_b == 0; i++) step();
      n_checks++;
      if (done_cnt_b != 1 || q_bytes_b.size() != EXP_LEN) begin
         n_fail++; $display("FAIL zg_frame: got dones=%0d bytes=%0d want 1/%0d", done_cnt_b, q_bytes_b.size(), EXP_LEN); return;
      end
      t0 = q_cyc_b[0];
      for (int i = 0; i < EXP_LEN; i++) begin
         n_checks++;
         if (q_bytes_b[i] !== exp_f[i] || q_cyc_b[i] != t0 + 3 * i) begin
            n_fail++; $display("FAIL zg_byte%0d: got %h@%0d want %h@%0d", i, q_bytes_b[i], q_cyc_b[i] - t0, exp_f[i], 3 * i);
         end
      end
      n_checks++;
      if (done_cyc_b - t0 != 3 * EXP_LEN) begin n_fail++; $display("FAIL zg_total: got %0d want %0d", done_cyc_b - t0, 3 * EXP_LEN); end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.res_valid = 1'b0; bus_a.res_data = '0; bus_a.glitch_flag = 1'b0; bus_a.sensor_word = '0;
      bus_b.res_valid = 1'b0; bus_b.res_data = '0; bus_b.glitch_flag = 1'b0; bus_b.sensor_word = '0;
      step();
      test_reset();
      test_zero_frame();
      test_known_vector();
      test_random();
      test_back_to_back();
      test_reset_mid_frame();
      test_zero_gap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_aes_resp_framer
`default_nettype wire
